vic_irq_arbiter: RTL and testbench
==================================

// Module: vic_irq_arbiter
// PURPOSE
//  Collects N peripheral interrupt lines, latches them as pending and applies a per-source mask.
//  Picks one winner at a time and drives vic_ctrl's i_ISR_addr/i_IRQ pair.
//  Blocks further requests until the ISR retires (i_reti), then tail-chains the next pending source.
//  Sits between the peripherals and vic_ctrl; the core's reti decode also feeds i_reti here.
// PARAMETERS
//  N_SRC     8  number of interrupt sources, 1..32; source i maps to ISR index i
//  IRQ_HOLD  2  cycles o_IRQ stays high per issue, >=1
// PORTS
//  clk           in   1      core clock
//  rst_n         in   1      asynchronous, active-low reset
//  i_irq_src     in   N_SRC  raw interrupt lines, asynchronous, rising-edge sensitive
//  i_mask_we     in   1      write strobe for the mask register
//  i_mask_wdata  in   N_SRC  new mask value; 1 = source disabled
//  i_reti        in   1      ISR return pulse from the core
//  o_mask        out  N_SRC  current mask
//  o_pending     out  N_SRC  pending bits, including masked ones
//  o_ISR_addr    out  5      index of the granted source, to vic_ctrl i_ISR_addr
//  o_IRQ         out  1      request to vic_ctrl i_IRQ
//  o_busy        out  1      high from grant until retire
//  o_spur_reti   out  1      1-cycle pulse when i_reti arrives while not in SVC
// BEHAVIOUR
//  Reset values: o_mask all-ones; pending 0; o_ISR_addr 0; o_IRQ 0; o_busy 0; o_spur_reti 0; state IDLE.
//  Input sync and edge detect
//   - Each i_irq_src bit passes a 2-flop synchronizer, then a rising-edge detector.
//   - An edge sets pending[i] on the following clock. Total latency is 3 clocks from the raw edge.
//   - Repeated edges while pending coalesce into one request.
//  Eligibility: eligible = pending & ~mask. Masked sources still latch; unmasking later makes them eligible.
//  Mask write: takes effect on the clock edge of i_mask_we and never cancels a grant already in progress.
//  State machine IDLE -> SETUP -> ISSUE -> SVC
//   - IDLE:  if eligible != 0, go to SETUP. Register o_ISR_addr = winner, clear pending[winner], set o_busy=1.
//   - SETUP: o_IRQ=0 for one cycle so the address is stable before the o_IRQ rising edge.
//   - ISSUE: o_IRQ=1 for exactly IRQ_HOLD cycles, then go to SVC.
//   - SVC:   o_IRQ=0. On i_reti:
//            eligible != 0 -> SETUP with the new winner latched on that same edge (tail-chain, o_busy stays 1);
//            eligible == 0 -> IDLE with o_busy=0.
//  i_reti in IDLE, SETUP or ISSUE: ignored for sequencing, and o_spur_reti pulses for one cycle.
//  Same-cycle events
//   - An edge on source i in the same cycle pending[i] is cleared by a grant: set wins, so pending[i] stays 1.
//   - A mask write in the same cycle as a grant decision: the decision uses the old mask.
//  Reset mid-operation: everything returns to reset values asynchronously and o_IRQ drops immediately.
//  o_ISR_addr holds its value outside grants. Upper bits are zero when N_SRC < 32.
// CONFIGURATION
//  VIC_ARB_ROUND_ROBIN_EN
//   - Undefined: fixed priority, lowest index wins.
//   - Defined: rotating priority. A pointer, reset value 0, is set to (winner+1) mod N_SRC on each grant,
//     and search starts at the pointer.
// STRUCTURE
//  vic_pkg holds: the state enum (IDLE/SETUP/ISSUE/SVC), VIC_ADDR_W=5, VIC_MAX_SRC=32.
//  Sub-module vic_prio_enc is combinational: inputs req[N_SRC] and start ptr; outputs valid and idx[4:0].
//  With RR disabled, ptr is tied to 0.
//  The top level holds the sync, pending and mask registers and the FSM.
// TESTING
//  1. Reset, write mask=0x00, pulse src[3] at t0.
//     -> pending[3] at t0+3; o_ISR_addr=3 at t0+4; o_IRQ high t0+5..t0+6; o_busy=1.
//  2. Edges on src[5] and src[2] together, fixed priority.
//     -> grant 2; on i_reti, tail-chain to 5 through SETUP with no IDLE gap; after the second reti, o_busy=0.
//  3. Mask=0x10, edge on src[4].
//     -> pending[4]=1 and no o_IRQ; write mask=0 -> grant 4 within 2 clocks.
//  4. i_reti pulse in IDLE.
//     -> o_spur_reti 1-cycle pulse; state stays IDLE; o_IRQ stays 0.
//  5. VIC_ARB_ROUND_ROBIN_EN defined; src 1 and 6 re-asserted continuously across retis.
//     -> grants alternate 1, 6, 1, 6.
//  6. rst_n low during ISSUE.
//     -> o_IRQ=0 and o_busy=0 with no clock; pending=0 and mask=0xFF after release.

Source files
------------

// File: rtl/vic_pkg.sv
// rtl/vic_pkg.sv - shared types and constants for the VIC interrupt arbiter
package vic_pkg;

   localparam int VIC_ADDR_W  = 5;
   localparam int VIC_MAX_SRC = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      ISSUE = 2'd2,
      SVC   = 2'd3
   } vic_state_e;

endpackage

// File: rtl/vic_prio_enc.sv
// rtl/vic_prio_enc.sv - circular priority encoder, search starts at ptr_i
module vic_prio_enc
   import vic_pkg::*;
#(
   parameter int N_SRC = 8
) (
   input  logic [N_SRC-1:0]      req_i,
   input  logic [VIC_ADDR_W-1:0] ptr_i,
   output logic                  valid_o,
   output logic [VIC_ADDR_W-1:0] idx_o
);

   logic                  hi_v;
   logic                  lo_v;
   logic [VIC_ADDR_W-1:0] hi_idx;
   logic [VIC_ADDR_W-1:0] lo_idx;

   // Lowest set index at or above the pointer wins; otherwise lowest set index below it
   always_comb begin
      hi_v   = 1'b0;
      lo_v   = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            if (i >= int'(ptr_i)) begin
               hi_v   = 1'b1;
               hi_idx = VIC_ADDR_W'(i);
            end else begin
               lo_v   = 1'b1;
               lo_idx = VIC_ADDR_W'(i);
            end
         end
      end
      valid_o = hi_v | lo_v;
      idx_o   = hi_v ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/vic_irq_arbiter.sv
// rtl/vic_irq_arbiter.sv - pending/mask latch and grant FSM feeding vic_ctrl; VIC_ARB_ROUND_ROBIN_EN selects rotating priority
module vic_irq_arbiter
   import vic_pkg::*;
#(
   parameter int N_SRC    = 8,
   parameter int IRQ_HOLD = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_SRC-1:0]      i_irq_src,
   input  logic                  i_mask_we,
   input  logic [N_SRC-1:0]      i_mask_wdata,
   input  logic                  i_reti,
   output logic [N_SRC-1:0]      o_mask,
   output logic [N_SRC-1:0]      o_pending,
   output logic [VIC_ADDR_W-1:0] o_ISR_addr,
   output logic                  o_IRQ,
   output logic                  o_busy,
   output logic                  o_spur_reti
);

   localparam int HOLD_W = (IRQ_HOLD > 1) ? $clog2(IRQ_HOLD) : 1;

   vic_state_e            state_q;
   logic [N_SRC-1:0]      sync1_q, sync2_q, sync3_q;
   logic [N_SRC-1:0]      pending_q, pending_d;
   logic [N_SRC-1:0]      mask_q;
   logic [N_SRC-1:0]      rise;
   logic [N_SRC-1:0]      eligible;
   logic [N_SRC-1:0]      win_oh;
   logic [VIC_ADDR_W-1:0] addr_q;
   logic [VIC_ADDR_W-1:0] ptr;
   logic [VIC_ADDR_W-1:0] win_idx;
   logic [HOLD_W-1:0]     hold_cnt_q;
   logic                  irq_q, busy_q, spur_q;
   logic                  win_valid;
   logic                  grant;

   assign rise     = sync2_q & ~sync3_q;
   assign eligible = pending_q & ~mask_q;
   assign grant    = win_valid && ((state_q == IDLE) || ((state_q == SVC) && i_reti));

   vic_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
      .req_i   (eligible),
      .ptr_i   (ptr),
      .valid_o (win_valid),
      .idx_o   (win_idx)
   );

   // One-hot of the winner, used to retire its pending bit on grant
   always_comb begin
      win_oh = '0;
      for (int i = 0; i < N_SRC; i++) begin
         win_oh[i] = grant && (win_idx == VIC_ADDR_W'(i));
      end
   end

   // A fresh edge beats the grant clear so a re-raise during grant is not lost
   always_comb begin
      pending_d = (pending_q & ~win_oh) | rise;
   end

   // Two-flop synchronizer plus a delayed copy for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
      end else begin
         sync1_q <= i_irq_src;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   // Pending and mask registers; sources come up disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         mask_q    <= '1;
      end else begin
         pending_q <= pending_d;
         if (i_mask_we) mask_q <= i_mask_wdata;
      end
   end

`ifdef VIC_ARB_ROUND_ROBIN_EN
   logic [VIC_ADDR_W-1:0] ptr_q;

   // Rotating priority: next search starts just past the last winner
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (grant) begin
         ptr_q <= (win_idx == VIC_ADDR_W'(N_SRC - 1)) ? '0 : win_idx + 1'b1;
      end
   end

   assign ptr = ptr_q;
`else
   assign ptr = '0;
`endif

   // Grant sequencer: latch winner, settle address, hold IRQ, wait for retire
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         irq_q      <= 1'b0;
         busy_q     <= 1'b0;
         spur_q     <= 1'b0;
         hold_cnt_q <= '0;
      end else begin
         spur_q <= i_reti && (state_q != SVC);
         case (state_q)
            IDLE: begin
               if (win_valid) begin
                  addr_q  <= win_idx;
                  busy_q  <= 1'b1;
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               irq_q      <= 1'b1;
               hold_cnt_q <= '0;
               state_q    <= ISSUE;
            end
            ISSUE: begin
               if (hold_cnt_q == HOLD_W'(IRQ_HOLD - 1)) begin
                  irq_q   <= 1'b0;
                  state_q <= SVC;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            SVC: begin
               if (i_reti) begin
                  if (win_valid) begin
                     addr_q  <= win_idx;
                     state_q <= SETUP;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_mask      = mask_q;
   assign o_pending   = pending_q;
   assign o_ISR_addr  = addr_q;
   assign o_IRQ       = irq_q;
   assign o_busy      = busy_q;
   assign o_spur_reti = spur_q;

endmodule

// File: tb/tb_vic_irq_arbiter.sv
// tb/tb_vic_irq_arbiter.sv - directed self-checking bench for vic_irq_arbiter
`timescale 1ns/1ps
module tb_vic_irq_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] i_irq_src;
   logic       i_mask_we;
   logic [7:0] i_mask_wdata;
   logic       i_reti;
   logic [7:0] o_mask;
   logic [7:0] o_pending;
   logic [4:0] o_ISR_addr;
   logic       o_IRQ;
   logic       o_busy;
   logic       o_spur_reti;

   int n_cmp;
   int n_err;
   logic [4:0] exp_seq [0:3];

   vic_irq_arbiter #(.N_SRC(8), .IRQ_HOLD(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_irq_src    (i_irq_src),
      .i_mask_we    (i_mask_we),
      .i_mask_wdata (i_mask_wdata),
      .i_reti       (i_reti),
      .o_mask       (o_mask),
      .o_pending    (o_pending),
      .o_ISR_addr   (o_ISR_addr),
      .o_IRQ        (o_IRQ),
      .o_busy       (o_busy),
      .o_spur_reti  (o_spur_reti)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic reti_pulse();
      i_reti = 1'b1;
      tick();
      i_reti = 1'b0;
   endtask

   task automatic mask_write(input logic [7:0] v);
      i_mask_we    = 1'b1;
      i_mask_wdata = v;
      tick();
      i_mask_we    = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
`ifdef VIC_ARB_ROUND_ROBIN_EN
      exp_seq[0] = 5'd1; exp_seq[1] = 5'd6; exp_seq[2] = 5'd1; exp_seq[3] = 5'd6;
`else
      exp_seq[0] = 5'd1; exp_seq[1] = 5'd1; exp_seq[2] = 5'd1; exp_seq[3] = 5'd1;
`endif
      rst_n = 1'b0; i_irq_src = '0; i_mask_we = 1'b0; i_mask_wdata = '0; i_reti = 1'b0;
      ticks(3);
      chk("rst_mask",    o_mask, 32'hFF);
      chk("rst_pending", o_pending, 32'h0);
      chk("rst_addr",    o_ISR_addr, 32'h0);
      chk("rst_irq",     o_IRQ, 32'h0);
      chk("rst_busy",    o_busy, 32'h0);
      chk("rst_spur",    o_spur_reti, 32'h0);
      rst_n = 1'b1;
      tick();

      // 1: single source, latency and IRQ window
      mask_write(8'h00);
      chk("t1_mask", o_mask, 32'h00);
      i_irq_src[3] = 1'b1;            // t0
      ticks(2);
      chk("t1_pend_t2", o_pending, 32'h00);
      tick();
      chk("t1_pend_t3", o_pending, 32'h08);
      tick();
      chk("t1_addr_t4", o_ISR_addr, 32'd3);
      chk("t1_busy_t4", o_busy, 32'h1);
      chk("t1_irq_t4",  o_IRQ, 32'h0);
      chk("t1_pclr_t4", o_pending, 32'h00);
      tick();
      chk("t1_irq_t5", o_IRQ, 32'h1);
      tick();
      chk("t1_irq_t6", o_IRQ, 32'h1);
      tick();
      chk("t1_irq_t7", o_IRQ, 32'h0);
      chk("t1_busy_svc", o_busy, 32'h1);
      i_irq_src[3] = 1'b0;
      ticks(2);
      chk("t1_addr_hold", o_ISR_addr, 32'd3);
      reti_pulse();
      chk("t1_busy_done", o_busy, 32'h0);
      chk("t1_nospur", o_spur_reti, 32'h0);

      // 2: simultaneous edges, fixed priority, tail-chain
      i_irq_src[5] = 1'b1;
      i_irq_src[2] = 1'b1;
      ticks(3);
      chk("t2_pend", o_pending, 32'h24);
      tick();
      chk("t2_addr0", o_ISR_addr, 32'd2);
      chk("t2_pend_left", o_pending, 32'h20);
      ticks(3);
      chk("t2_svc_irq", o_IRQ, 32'h0);
      reti_pulse();
      chk("t2_addr1", o_ISR_addr, 32'd5);
      chk("t2_busy_chain", o_busy, 32'h1);
      chk("t2_irq_setup", o_IRQ, 32'h0);
      chk("t2_pend_empty", o_pending, 32'h00);
      tick();
      chk("t2_irq_issue", o_IRQ, 32'h1);
      ticks(2);
      chk("t2_irq_svc2", o_IRQ, 32'h0);
      reti_pulse();
      chk("t2_busy_done", o_busy, 32'h0);
      i_irq_src = '0;
      ticks(2);

      // 3: masked source latches, unmask releases it
      mask_write(8'h10);
      i_irq_src[4] = 1'b1;
      ticks(3);
      chk("t3_pend_masked", o_pending, 32'h10);
      ticks(2);
      chk("t3_no_irq", o_IRQ, 32'h0);
      chk("t3_no_busy", o_busy, 32'h0);
      mask_write(8'h00);
      chk("t3_old_mask_busy", o_busy, 32'h0);
      tick();
      chk("t3_grant_busy", o_busy, 32'h1);
      chk("t3_grant_addr", o_ISR_addr, 32'd4);
      ticks(3);
      reti_pulse();
      chk("t3_done", o_busy, 32'h0);
      i_irq_src = '0;
      ticks(2);

      // 4: spurious reti in IDLE
      reti_pulse();
      chk("t4_spur_hi", o_spur_reti, 32'h1);
      chk("t4_irq", o_IRQ, 32'h0);
      chk("t4_busy", o_busy, 32'h0);
      tick();
      chk("t4_spur_lo", o_spur_reti, 32'h0);
      chk("t4_idle_irq", o_IRQ, 32'h0);

      // 5: sources 1 and 6 repeatedly re-raised across retis
      i_irq_src[1] = 1'b1;
      i_irq_src[6] = 1'b1;
      ticks(3);
      chk("t5_pend", o_pending, 32'h42);
      for (int r = 0; r < 4; r++) begin
         if (r == 0) tick();
         else reti_pulse();
         chk($sformatf("t5_grant%0d", r), o_ISR_addr, 32'(exp_seq[r]));
         if (r < 3) begin
            i_irq_src[1] = 1'b0;
            i_irq_src[6] = 1'b0;
            ticks(3);
            i_irq_src[1] = 1'b1;
            i_irq_src[6] = 1'b1;
            ticks(3);
         end
      end

      // 6: asynchronous reset while issuing
      tick();
      chk("t6_irq_issue", o_IRQ, 32'h1);
      rst_n = 1'b0;
      #2;
      chk("t6_irq_async", o_IRQ, 32'h0);
      chk("t6_busy_async", o_busy, 32'h0);
      i_irq_src = '0;
      ticks(2);
      rst_n = 1'b1;
      tick();
      chk("t6_pend", o_pending, 32'h00);
      chk("t6_mask", o_mask, 32'hFF);
      chk("t6_addr", o_ISR_addr, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
